// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues in-order imem requests,
// buffers returned words in a small fetch queue and drives the IF/ID register.
module if_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_pc4
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  // stale responses from back-to-back redirects can stack beyond one queue's worth
  localparam int DW = AW + 3;
  localparam logic [WIDTH-1:0] NOP        = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [WIDTH-1:0] pc;
  logic [AW-1:0]    head, tail, fptr;
  logic [CW-1:0]    occ, n_unf;
  logic [DW-1:0]    drop_cnt;
  logic [QDEPTH-1:0] filled;
  logic [WIDTH-1:0] q_pc    [QDEPTH];
  logic [WIDTH-1:0] q_instr [QDEPTH];

  logic             alloc, fill, dropping, rv_consumed;
  logic             head_filled, bypass, pop;
  logic [WIDTH-1:0] head_instr;

  assign imem_req  = rst_n && (occ < CW'(QDEPTH)) && !redirect;
  assign imem_addr = pc;

  assign alloc       = imem_req && imem_gnt;
  assign dropping    = imem_rvalid && (drop_cnt != '0);
  assign fill        = imem_rvalid && (drop_cnt == '0) && (n_unf != '0);
  assign rv_consumed = imem_rvalid && ((drop_cnt != '0) || (n_unf != '0));

  // an unfilled head is always the oldest unfilled entry, so a fill there can bypass
  assign head_filled = (occ != '0) && filled[head];
  assign bypass      = (occ != '0) && fill && (fptr == head);
  assign pop         = !redirect && !stall && (head_filled || bypass);
  assign head_instr  = filled[head] ? q_instr[head] : imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      occ      <= '0;
      n_unf    <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      id_valid <= 1'b0;
      id_instr <= NOP;
      id_pc    <= RESET_PC;
      id_pc4   <= RESET_PC + PC_STEP;
    end else if (redirect) begin
      pc       <= redirect_pc & ALIGN_MASK;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      occ      <= '0;
      n_unf    <= '0;
      filled   <= '0;
      drop_cnt <= drop_cnt + DW'(n_unf) + DW'(alloc) - DW'(rv_consumed);
      id_valid <= 1'b0;
      id_instr <= NOP;
    end else begin
      if (alloc) begin
        pc           <= pc + PC_STEP;
        tail         <= tail + AW'(1);
        filled[tail] <= 1'b0;
      end
      if (fill) begin
        fptr         <= fptr + AW'(1);
        filled[fptr] <= 1'b1;
      end
      if (dropping)
        drop_cnt <= drop_cnt - DW'(1);
      if (pop)
        head <= head + AW'(1);
      occ   <= occ + CW'(alloc) - CW'(pop);
      n_unf <= n_unf + CW'(alloc) - CW'(fill);
      if (!stall) begin
        if (pop) begin
          id_valid <= 1'b1;
          id_instr <= head_instr;
          id_pc    <= q_pc[head];
          id_pc4   <= q_pc[head] + PC_STEP;
        end else begin
          id_valid <= 1'b0;
          id_instr <= NOP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc)
      q_pc[tail] <= pc;
    if (fill)
      q_instr[fptr] <= imem_rdata;
  end

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> ((drop_cnt != '0) || (n_unf != '0)));

endmodule
